pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Controls the PLL wrapper from the other side of its rst/locked interface. Drives the PLL's
//  active-high rst and watches its asynchronous locked output. Debounces lock and releases
//  the downstream system reset. On lock loss or lock timeout it re-resets the PLL and retries.
//  Sits in the refclk domain (free-running 50 MHz board clock), between board reset and PLL.
// PARAMETERS
//  RST_CYCLES     16     refclk cycles pll_rst is held high per reset attempt (>=1)
//  LOCK_TIMEOUT   50000  cycles to wait for locked after pll_rst release (1 ms @ 50 MHz)
//  STABLE_CYCLES  1024   consecutive synchronized-locked cycles required before release
//  MAX_RETRIES    8      consecutive timeouts before FAIL (>=1)
// PORTS
//  refclk      in   1  free-running reference clock; sole clock of this block
//  rst_n       in   1  asynchronous, active-low reset
//  restart     in   1  sync pulse: abort and restart sequence, clear retry count
//  pll_locked  in   1  PLL locked, asynchronous to refclk
//  pll_rst     out  1  to PLL rst, active high
//  sys_rst_n   out  1  downstream reset, active low; high only in RUN
//  ready       out  1  high in RUN
//  fail        out  1  high in FAIL
//  retry_cnt   out  4  consecutive timeouts since last RUN/restart, saturating at 15
// BEHAVIOUR
//  - pll_locked passes a 2-flop synchronizer -> locked_s (2-cycle latency). All outputs registered.
//  - rst_n low: state=RESET_PLL, timer=0, retry_cnt=0, pll_rst=1, sys_rst_n=0, ready=0, fail=0.
//  - RESET_PLL: pll_rst=1; timer counts to RST_CYCLES-1, then timer=0 -> WAIT_LOCK.
//  - WAIT_LOCK: pll_rst=0. locked_s=1 -> DEBOUNCE, timer=0.
//    timer==LOCK_TIMEOUT-1 -> retry_cnt++. If new count==MAX_RETRIES -> FAIL, else -> RESET_PLL.
//  - DEBOUNCE: locked_s=0 -> WAIT_LOCK with timer=0 (fresh timeout).
//    timer==STABLE_CYCLES-1 with locked_s=1 -> RUN, retry_cnt=0.
//  - RUN: sys_rst_n=1, ready=1. locked_s=0 -> RESET_PLL. sys_rst_n/ready drop next edge.
//    A lock loss does not increment retry_cnt.
//  - FAIL: pll_rst=1, fail=1, sys_rst_n=0. Exits only via restart or rst_n.
//  - restart=1 has priority in every state, incl. same cycle as locked_s change or timeout:
//    next state RESET_PLL, timer=0, retry_cnt=0, fail=0.
//  - Release latency: pll_locked rise to sys_rst_n rise = 2 + STABLE_CYCLES + 1 cycles
//    (provided locked stays high).
//  - Timer: single shared counter, width $clog2(max of RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1.
//    Cleared on every state change.
//  - Glitch of locked shorter than 1 refclk period may be missed; a drop seen by locked_s
//    is always acted on.
// CONFIGURATION
//  PLL_SEQ_LOSS_COUNT_EN defined: adds output loss_cnt[7:0]. Increments on each RUN->RESET_PLL
//   lock-loss transition, saturates at 255. Cleared only by rst_n (not by restart).
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package pll_seq_pkg:
//   - state enum {RESET_PLL, WAIT_LOCK, DEBOUNCE, RUN, FAIL}, 3 bits
//   - timer-width function
//   - RETRY_W=4 constant
//  Sub-module sync_2ff: 2-flop synchronizer, async active-low reset to 0. Used for pll_locked.
//  FSM, timer, counters and output regs in this module.
// TESTING  (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=3)
//  1. Reset release; locked rises 10 cycles after pll_rst falls.
//     -> pll_rst high exactly 4 cycles; sys_rst_n/ready rise 11 cycles after locked.
//  2. locked never rises -> three 100-cycle waits, retry_cnt 1,2,3.
//     -> fail=1 and pll_rst=1 after 3rd timeout; restart pulse -> fail=0, retry_cnt=0, pll_rst 4 cycles.
//  3. In DEBOUNCE, locked drops after 5 cycles, then returns.
//     -> back to WAIT_LOCK, no release; full 8-cycle debounce restarts.
//  4. In RUN, locked drops.
//     -> sys_rst_n=0, ready=0 by 3rd edge after drop; pll_rst pulses 4 cycles;
//        loss_cnt=1 when PLL_SEQ_LOSS_COUNT_EN is defined.
//  5. restart on the same cycle as the WAIT_LOCK timeout with retry_cnt=2.
//     -> RESET_PLL, retry_cnt=0, fail stays 0.
//  6. rst_n asserted mid-DEBOUNCE and mid-RUN.
//     -> all outputs at reset values asynchronously; full sequence reruns after release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer: FSM state encoding,
// retry/loss counter widths and the shared-timer width calculation.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      DEBOUNCE  = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   localparam int RETRY_W = 4;
   localparam int LOSS_W  = 8;

   // One counter serves every timed state, so it must cover the longest interval.
   function automatic int timer_width(input int rst_cycles, input int lock_timeout,
                                      input int stable_cycles);
      int m;
      m = rst_cycles;
      if (lock_timeout > m) m = lock_timeout;
      if (stable_cycles > m) m = stable_cycles;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages clear to 0
// under the asynchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, debounces the synchronized lock,
// releases sys_rst_n, retries on timeout. PLL_SEQ_LOSS_COUNT_EN adds loss_cnt.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 8
) (
   input  logic               refclk,
   input  logic               rst_n,
   input  logic               restart,
   input  logic               pll_locked,
   output logic               pll_rst,
   output logic               sys_rst_n,
   output logic               ready,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_COUNT_EN
   ,output logic [LOSS_W-1:0] loss_cnt
`endif
);

   localparam int TIMER_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

   localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_SAT   = {RETRY_W{1'b1}};
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

   logic               locked_s;
   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [RETRY_W-1:0] retry_inc;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_rst_n_q, sys_rst_n_d;
   logic               ready_q, ready_d;
   logic               fail_q, fail_d;

   sync_2ff u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_PLL;
         timer_q     <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 1'b1;
      retry_d   = retry_q;
      retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;

      // restart outranks lock changes and timeouts arriving on the same edge
      if (restart) begin
         state_d = RESET_PLL;
         timer_d = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            RESET_PLL: begin
               if (timer_q == RST_LAST) begin
                  state_d = WAIT_LOCK;
                  timer_d = '0;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = DEBOUNCE;
                  timer_d = '0;
               end else if (timer_q == LOCK_LAST) begin
                  retry_d = retry_inc;
                  timer_d = '0;
                  state_d = (retry_inc == RETRY_LIMIT) ? FAIL : RESET_PLL;
               end
            end
            DEBOUNCE: begin
               if (!locked_s) begin
                  state_d = WAIT_LOCK;
                  timer_d = '0;
               end else if (timer_q == STABLE_LAST) begin
                  state_d = RUN;
                  timer_d = '0;
                  retry_d = '0;
               end
            end
            RUN: begin
               timer_d = '0;
               if (!locked_s) begin
                  state_d = RESET_PLL;
               end
            end
            FAIL: begin
               timer_d = '0;
            end
            default: begin
               state_d = RESET_PLL;
               timer_d = '0;
            end
         endcase
      end

      // outputs decode the next state so they change on the same edge as the state
      pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAIL);
      sys_rst_n_d = (state_d == RUN);
      ready_d     = (state_d == RUN);
      fail_d      = (state_d == FAIL);
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst_n = sys_rst_n_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic [LOSS_W-1:0] loss_q, loss_d;

   always_comb begin
      loss_d = loss_q;
      if ((state_q == RUN) && !restart && !locked_s && (loss_q != {LOSS_W{1'b1}})) begin
         loss_d = loss_q + 1'b1;
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output-change events with cycle stamps;
// a negedge monitor pops and compares whenever any DUT output changes.
module tb_pll_reset_sequencer;

   logic       refclk = 1'b0;
   logic       rst_n = 1'b1;
   logic       restart = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic       fail;
   logic [3:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic [7:0] loss_cnt;
`endif

   pll_reset_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (100),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (3)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .restart    (restart),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_rst_n  (sys_rst_n),
      .ready      (ready),
      .fail       (fail),
      .retry_cnt  (retry_cnt)
`ifdef PLL_SEQ_LOSS_COUNT_EN
      ,.loss_cnt  (loss_cnt)
`endif
   );

   always #5 refclk = ~refclk;

   int cyc = 0;
   always @(posedge refclk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic       pr;
      logic       sr;
      logic       rd;
      logic       fl;
      logic [3:0] rt;
      logic [7:0] ls;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;

   function automatic logic [7:0] loss_now();
`ifdef PLL_SEQ_LOSS_COUNT_EN
      return loss_cnt;
`else
      return 8'd0;
`endif
   endfunction

   function automatic logic [7:0] loss_mask(input logic [7:0] v);
`ifdef PLL_SEQ_LOSS_COUNT_EN
      return v;
`else
      return 8'd0 & v;
`endif
   endfunction

   task automatic push(input int c, input logic pr, input logic sr, input logic rd,
                       input logic fl, input logic [3:0] rt, input logic [7:0] ls);
      ev_t e;
      e.cyc = c; e.pr = pr; e.sr = sr; e.rd = rd; e.fl = fl; e.rt = rt; e.ls = ls;
      exp_q.push_back(e);
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic check_reset(input string tag);
      logic [15:0] got;
      got = {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_now()};
      checks++;
      if (got !== 16'h8000) begin
         failures++;
         $display("FAIL %s cyc=%0d got {pr,sr,rd,fl,rt,ls}=%h required=8000", tag, cyc, got);
      end else begin
         $display("chk %s cyc=%0d outputs at reset values", tag, cyc);
      end
   endtask

   // monitor: one scoreboard comparison per observed output change
   initial begin
      logic [15:0] prev;
      logic [15:0] cur;
      logic [15:0] want;
      ev_t         e;
      prev = 16'h8000;
      forever begin
         @(negedge refclk);
         cur = {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_now()};
         if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               want = {e.pr, e.sr, e.rd, e.fl, e.rt, loss_mask(e.ls)};
               if ((e.cyc != cyc) || (cur !== want)) begin
                  failures++;
                  $display("FAIL event cyc=%0d got=%h required cyc=%0d val=%h",
                           cyc, cur, e.cyc, want);
               end else begin
                  $display("ev cyc=%0d pr=%0b sr=%0b rd=%0b fl=%0b rt=%0d ls=%0d",
                           cyc, e.pr, e.sr, e.rd, e.fl, e.rt, e.ls);
               end
            end
            prev = cur;
         end
      end
   end

   initial begin
      int r, a, b, c, d, e, f, g, h, i, j, spin;
      #1 rst_n = 1'b0;
      #1 check_reset("por");

      // 1: release, lock 10 cycles after pll_rst falls, release 11 cycles later
      goto(3);
      rst_n = 1'b1;
      r = cyc;
      push(r + 4, 0, 0, 0, 0, 4'd0, 8'd0);
      goto(r + 14);
      pll_locked = 1'b1;
      push(r + 25, 0, 1, 1, 0, 4'd0, 8'd0);

      // 4: lock loss in RUN
      a = r + 30;
      goto(a);
      pll_locked = 1'b0;
      push(a + 3, 1, 0, 0, 0, 4'd0, 8'd1);
      push(a + 7, 0, 0, 0, 0, 4'd0, 8'd1);

      // 3: lock drops 5 cycles into DEBOUNCE, then returns for a full debounce
      b = a + 10;
      goto(b);
      pll_locked = 1'b1;
      goto(b + 7);
      pll_locked = 1'b0;
      c = b + 12;
      goto(c);
      pll_locked = 1'b1;
      push(c + 11, 0, 1, 1, 0, 4'd0, 8'd1);

      // 6a: rst_n mid-RUN
      d = c + 15;
      goto(d);
      rst_n = 1'b0;
      pll_locked = 1'b0;
      push(d, 1, 0, 0, 0, 4'd0, 8'd0);
      #1 check_reset("rst_in_run");
      e = d + 3;
      goto(e);
      rst_n = 1'b1;
      push(e + 4, 0, 0, 0, 0, 4'd0, 8'd0);

      // 6b: rst_n mid-DEBOUNCE, then a full rerun
      f = e + 6;
      goto(f);
      pll_locked = 1'b1;
      goto(f + 6);
      rst_n = 1'b0;
      pll_locked = 1'b0;
      push(f + 6, 1, 0, 0, 0, 4'd0, 8'd0);
      #1 check_reset("rst_in_debounce");
      g = f + 8;
      goto(g);
      rst_n = 1'b1;
      push(g + 4, 0, 0, 0, 0, 4'd0, 8'd0);
      h = g + 6;
      goto(h);
      pll_locked = 1'b1;
      push(h + 11, 0, 1, 1, 0, 4'd0, 8'd0);

      // 2: restart from RUN (not a lock loss), lock never returns -> three timeouts -> FAIL
      i = h + 14;
      goto(i);
      pll_locked = 1'b0;
      restart = 1'b1;
      push(i + 1, 1, 0, 0, 0, 4'd0, 8'd0);
      goto(i + 1);
      restart = 1'b0;
      push(i + 5,   0, 0, 0, 0, 4'd0, 8'd0);
      push(i + 105, 1, 0, 0, 0, 4'd1, 8'd0);
      push(i + 109, 0, 0, 0, 0, 4'd1, 8'd0);
      push(i + 209, 1, 0, 0, 0, 4'd2, 8'd0);
      push(i + 213, 0, 0, 0, 0, 4'd2, 8'd0);
      push(i + 313, 1, 0, 0, 1, 4'd3, 8'd0);
      j = i + 330;
      goto(j);
      restart = 1'b1;
      push(j + 1, 1, 0, 0, 0, 4'd0, 8'd0);
      goto(j + 1);
      restart = 1'b0;
      push(j + 5, 0, 0, 0, 0, 4'd0, 8'd0);

      // 5: restart on the same edge as the second timeout
      push(j + 105, 1, 0, 0, 0, 4'd1, 8'd0);
      push(j + 109, 0, 0, 0, 0, 4'd1, 8'd0);
      push(j + 209, 1, 0, 0, 0, 4'd2, 8'd0);
      push(j + 213, 0, 0, 0, 0, 4'd2, 8'd0);
      goto(j + 312);
      restart = 1'b1;
      push(j + 313, 1, 0, 0, 0, 4'd0, 8'd0);
      goto(j + 313);
      restart = 1'b0;
      push(j + 317, 0, 0, 0, 0, 4'd0, 8'd0);

      goto(j + 330);
      spin = 0;
      while ((exp_q.size() != 0) && (spin < 50)) begin
         @(posedge refclk);
         spin++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0 next_cyc=%0d", exp_q.size(), exp_q[0].cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
